// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for a combinational-ROM fetch: ProgCtr updates one cycle after its cause.
// Optional run-cycle counter output CycleCnt when FETCH_CYCLE_CNT_EN is defined.
module fetch_sequencer #(
   parameter int A = 12
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Start,
   input  logic [A-1:0] StartAddr,
   input  logic         Halt,
   input  logic         Stall,
   input  logic         BranchAbs,
   input  logic         BranchRel,
   input  logic         Taken,
   input  logic [A-1:0] Target,
   output logic [A-1:0] ProgCtr,
   output logic         Busy,
   output logic         Done
`ifdef FETCH_CYCLE_CNT_EN
   ,
   output logic [15:0]  CycleCnt
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;

   // Busy/Done are registered alongside state so they never see input glitches.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state   <= IDLE;
         ProgCtr <= '0;
         Busy    <= 1'b0;
         Done    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (Start) begin
                  state   <= RUN;
                  ProgCtr <= StartAddr;
                  Busy    <= 1'b1;
                  Done    <= 1'b0;
               end
            end
            RUN: begin
               if (Halt) begin
                  state <= DONE;
                  Busy  <= 1'b0;
                  Done  <= 1'b1;
               end else if (Stall) begin
                  ProgCtr <= ProgCtr;
               end else if (BranchAbs && Taken) begin
                  ProgCtr <= Target;
               end else if (BranchRel && Taken) begin
                  // Unsigned add of the two's-complement offset wraps modulo 2^A.
                  ProgCtr <= ProgCtr + Target;
               end else begin
                  ProgCtr <= ProgCtr + A'(1);
               end
            end
            default: begin
               state   <= IDLE;
               ProgCtr <= '0;
               Busy    <= 1'b0;
               Done    <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_CYCLE_CNT_EN
   always_ff @(posedge Clk) begin
      if (Reset) begin
         CycleCnt <= '0;
      end else if (state == RUN) begin
         if (CycleCnt != 16'hFFFF)
            CycleCnt <= CycleCnt + 16'd1;
      end else if (Start) begin
         CycleCnt <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus queues hand-computed expectations, monitor checks after each edge.
module tb_fetch_sequencer;

   localparam int A = 12;

   logic         Clk = 1'b0;
   logic         Reset, Start, Halt, Stall, BranchAbs, BranchRel, Taken;
   logic [A-1:0] StartAddr, Target;
   logic [A-1:0] ProgCtr;
   logic         Busy, Done;
`ifdef FETCH_CYCLE_CNT_EN
   logic [15:0]  CycleCnt;
`endif

   fetch_sequencer #(.A(A)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
      .Halt(Halt), .Stall(Stall), .BranchAbs(BranchAbs), .BranchRel(BranchRel),
      .Taken(Taken), .Target(Target), .ProgCtr(ProgCtr), .Busy(Busy), .Done(Done)
`ifdef FETCH_CYCLE_CNT_EN
      , .CycleCnt(CycleCnt)
`endif
   );

   always #5 Clk = ~Clk;

   typedef struct {
      string        name;
      logic [A-1:0] pc;
      logic         busy;
      logic         done;
      logic         chk_cnt;
      logic [15:0]  cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always @(posedge Clk) begin
      #1;
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_cmp++;
         if (ProgCtr !== e.pc) begin
            n_bad++;
            $display("FAIL %s ProgCtr got %h want %h", e.name, ProgCtr, e.pc);
         end
         n_cmp++;
         if (Busy !== e.busy) begin
            n_bad++;
            $display("FAIL %s Busy got %b want %b", e.name, Busy, e.busy);
         end
         n_cmp++;
         if (Done !== e.done) begin
            n_bad++;
            $display("FAIL %s Done got %b want %b", e.name, Done, e.done);
         end
`ifdef FETCH_CYCLE_CNT_EN
         if (e.chk_cnt) begin
            n_cmp++;
            if (CycleCnt !== e.cnt) begin
               n_bad++;
               $display("FAIL %s CycleCnt got %0d want %0d", e.name, CycleCnt, e.cnt);
            end
         end
`endif
      end
   end

   // One clock of stimulus; ctl = {Reset,Start,Halt,Stall,BranchAbs,BranchRel,Taken}.
   task automatic cyc(input string nm, input logic [6:0] ctl, input logic [A-1:0] sa,
                      input logic [A-1:0] tg, input logic [A-1:0] pc, input logic bsy,
                      input logic dn, input logic cc = 1'b0, input logic [15:0] cnt = 16'd0);
      exp_t e;
      {Reset, Start, Halt, Stall, BranchAbs, BranchRel, Taken} = ctl;
      StartAddr = sa;
      Target    = tg;
      e.name = nm; e.pc = pc; e.busy = bsy; e.done = dn; e.chk_cnt = cc; e.cnt = cnt;
      exp_q.push_back(e);
      @(posedge Clk);
      #2;
   endtask

   localparam logic [6:0] RST  = 7'b1000000;
   localparam logic [6:0] NOP  = 7'b0000000;
   localparam logic [6:0] STRT = 7'b0100000;
   localparam logic [6:0] HLT  = 7'b0010000;
   localparam logic [6:0] STL  = 7'b0001000;
   localparam logic [6:0] ABS  = 7'b0000101;
   localparam logic [6:0] REL  = 7'b0000011;
   localparam logic [6:0] RELN = 7'b0000010;
   localparam logic [6:0] BOTH = 7'b0000111;

   initial begin
      Reset = 1'b1; Start = 0; Halt = 0; Stall = 0; BranchAbs = 0; BranchRel = 0; Taken = 0;
      StartAddr = '0; Target = '0;
      @(posedge Clk); #2;

      cyc("reset",       RST,  12'h000, 12'h000, 12'h000, 0, 0, 1'b1, 16'd0);
      cyc("idle_hold",   NOP,  12'h000, 12'h000, 12'h000, 0, 0);
      cyc("start_010",   STRT, 12'h010, 12'h000, 12'h010, 1, 0);
      cyc("inc_011",     NOP,  12'h000, 12'h000, 12'h011, 1, 0);
      cyc("inc_012",     NOP,  12'h000, 12'h000, 12'h012, 1, 0);
      cyc("abs_020",     ABS,  12'h000, 12'h020, 12'h020, 1, 0);
      cyc("rel_neg4",    REL,  12'h000, 12'hFFC, 12'h01C, 1, 0);
      cyc("abs_020b",    ABS,  12'h000, 12'h020, 12'h020, 1, 0);
      cyc("rel_untaken", RELN, 12'h000, 12'hFFC, 12'h021, 1, 0);
      cyc("rel_pos",     REL,  12'h000, 12'h00F, 12'h030, 1, 0);
      cyc("abs_over_rel",BOTH, 12'h000, 12'h100, 12'h100, 1, 0);
      cyc("abs_040",     ABS,  12'h000, 12'h040, 12'h040, 1, 0);
      cyc("stall_br",    STL | ABS, 12'h000, 12'h100, 12'h040, 1, 0);
      cyc("start_in_run",STRT, 12'h555, 12'h000, 12'h041, 1, 0);
      cyc("abs_005",     ABS,  12'h000, 12'h005, 12'h005, 1, 0);
      cyc("halt_005",    HLT | STL | ABS, 12'h000, 12'h200, 12'h005, 0, 1);
      cyc("done_hold",   ABS,  12'h000, 12'h300, 12'h005, 0, 1);
      cyc("restart_000", STRT, 12'h000, 12'h000, 12'h000, 1, 0);
      cyc("halt_000",    HLT,  12'h000, 12'h000, 12'h000, 0, 1);
      cyc("start_FFF",   STRT, 12'hFFF, 12'h000, 12'hFFF, 1, 0);
      cyc("wrap_000",    NOP,  12'h000, 12'h000, 12'h000, 1, 0);
      cyc("abs_123",     ABS,  12'h000, 12'h123, 12'h123, 1, 0);
      cyc("reset_mid",   RST | STRT | HLT | STL | ABS, 12'h777, 12'h456, 12'h000, 0, 0);
      cyc("post_reset",  NOP,  12'h000, 12'h000, 12'h000, 0, 0);

      // 10 RUN cycles: 3 stalls, 6 plain, terminating halt
      cyc("cnt_start",   STRT, 12'h000, 12'h000, 12'h000, 1, 0, 1'b1, 16'd0);
      cyc("cnt_1",  NOP, 12'h000, 12'h000, 12'h001, 1, 0, 1'b1, 16'd1);
      cyc("cnt_2",  STL, 12'h000, 12'h000, 12'h001, 1, 0, 1'b1, 16'd2);
      cyc("cnt_3",  NOP, 12'h000, 12'h000, 12'h002, 1, 0, 1'b1, 16'd3);
      cyc("cnt_4",  STL, 12'h000, 12'h000, 12'h002, 1, 0, 1'b1, 16'd4);
      cyc("cnt_5",  NOP, 12'h000, 12'h000, 12'h003, 1, 0, 1'b1, 16'd5);
      cyc("cnt_6",  STL, 12'h000, 12'h000, 12'h003, 1, 0, 1'b1, 16'd6);
      cyc("cnt_7",  NOP, 12'h000, 12'h000, 12'h004, 1, 0, 1'b1, 16'd7);
      cyc("cnt_8",  NOP, 12'h000, 12'h000, 12'h005, 1, 0, 1'b1, 16'd8);
      cyc("cnt_9",  NOP, 12'h000, 12'h000, 12'h006, 1, 0, 1'b1, 16'd9);
      cyc("cnt_10", HLT, 12'h000, 12'h000, 12'h006, 0, 1, 1'b1, 16'd10);
      cyc("cnt_hold", NOP, 12'h000, 12'h000, 12'h006, 0, 1, 1'b1, 16'd10);
      cyc("cnt_clear", STRT, 12'h040, 12'h000, 12'h040, 1, 0, 1'b1, 16'd0);
      cyc("cnt_reset", RST, 12'h000, 12'h000, 12'h000, 0, 0, 1'b1, 16'd0);

      cyc("tail", NOP, 12'h000, 12'h000, 12'h000, 0, 0);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge Clk);
      #3;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain %0d left want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter A, default 12, meaning instruction address width; it matches the instruction ROM address width.
REQ-002 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port Start, input, 1 bit: request to begin a program run.
REQ-005 The block SHALL have port StartAddr, input, A bits: first instruction address of a run.
REQ-006 The block SHALL have port Halt, input, 1 bit: current instruction decodes as halt.
REQ-007 The block SHALL have port Stall, input, 1 bit: hold the PC this cycle.
REQ-008 The block SHALL have port BranchAbs, input, 1 bit: current instruction is an absolute branch.
REQ-009 The block SHALL have port BranchRel, input, 1 bit: current instruction is a relative branch.
REQ-010 The block SHALL have port Taken, input, 1 bit: branch condition true.
REQ-011 The block SHALL have port Target, input, A bits: absolute address, or two's-complement offset for relative branches.
REQ-012 The block SHALL have port ProgCtr, output, A bits: registered PC; drives the ROM InstAddress.
REQ-013 The block SHALL have port Busy, output, 1 bit: high while in RUN.
REQ-014 The block SHALL have port Done, output, 1 bit: high while in DONE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-016 In IDLE or DONE with Start=1: ProgCtr<=StartAddr and next state RUN; Done drops the same edge.
REQ-017 In IDLE or DONE with Start=0: state and ProgCtr SHALL hold.
REQ-018 In RUN, Start SHALL be ignored.
REQ-019 In RUN, per-cycle priority SHALL be: Halt > Stall > (BranchAbs&Taken) > (BranchRel&Taken) > increment.
REQ-020 Halt in RUN: next state DONE; ProgCtr holds at the halt address.
REQ-021 Stall in RUN (no Halt): ProgCtr holds; state stays RUN.
REQ-022 Taken absolute branch: ProgCtr<=Target; when BranchAbs and BranchRel are both high, absolute wins.
REQ-023 Taken relative branch: ProgCtr<=(ProgCtr+Target) mod 2^A, with Target sign-interpreted.
REQ-024 Untaken branch or plain instruction: ProgCtr<=(ProgCtr+1) mod 2^A; 2^A-1 wraps to 0 silently.
REQ-025 Branch inputs with Taken=0 SHALL behave as increment.
REQ-026 Busy SHALL be (state==RUN) and Done SHALL be (state==DONE), both registered-state decodes with no combinational path from inputs.
REQ-027 ProgCtr change latency SHALL be one cycle; the instruction for the new PC is valid in the same cycle because the ROM read is combinational.

Reset
REQ-028 Reset=1 at a clock edge SHALL force state IDLE, ProgCtr=0, Busy=0, Done=0, overriding every other input including a mid-run Start, Halt or branch.
REQ-029 After Reset deasserts, the block SHALL stay in IDLE until Start.

Configuration
REQ-030 With FETCH_CYCLE_CNT_EN defined, the block SHALL have an extra output CycleCnt[15:0] that counts every clock spent in RUN (stalls included), clears to 0 on accepted Start and on Reset, saturates at 65535, and holds in DONE/IDLE.
REQ-031 Without FETCH_CYCLE_CNT_EN, the CycleCnt port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-032 The bench SHALL cover: Reset, then Start with StartAddr=0x010 -> Busy=1, ProgCtr=0x010 on the next cycle, then 0x011 and 0x012 on successive cycles.
REQ-033 The bench SHALL cover: PC=0x020 with BranchRel=1, Taken=1, Target=0xFFC -> ProgCtr=0x01C; the same stimulus with Taken=0 -> ProgCtr=0x021.
REQ-034 The bench SHALL cover: PC=0x030 with BranchAbs=1, BranchRel=1, Taken=1, Target=0x100 -> ProgCtr=0x100; PC=0x040 with Stall=1 and BranchAbs=1, Taken=1 -> ProgCtr holds 0x040.
REQ-035 The bench SHALL cover: Start with StartAddr=0xFFF, one cycle -> ProgCtr=0x000 and Busy remains 1.
REQ-036 The bench SHALL cover: Halt=1 at PC=0x005 -> Done=1, Busy=0, ProgCtr=0x005 held; Start with StartAddr=0x000 -> RUN and Done=0 on the next cycle.
REQ-037 The bench SHALL cover: Reset asserted mid-run at PC=0x123 with Stall=1 -> next cycle IDLE, ProgCtr=0; with FETCH_CYCLE_CNT_EN, a 10-cycle run including 3 stalls -> CycleCnt=10.
